// File: rtl/id_ex_wb_datapath.sv
// ---------------------------------------------------------------------------
// id_ex_wb_datapath
//
// Back end of the 8-bit MOV/SLL pipeline: ID stage (register-file read with
// operand forwarding), ID/EX register, EX stage (move or shift-left), EX/WB
// register, and write-back into the register file.
//
// Ports
//   Clk                     clock, all state updates on the rising edge
//   Reset                   asynchronous, active-low reset
//   IF_ID_RegWrite          instruction in ID writes its destination
//   IF_ID_SMCtrl            1 = SLL, 0 = MOV
//   IF_ID_Instruction_Code  [7:6] opcode (unused), [5:3] rd, [2:0] rs/shamt
//   Dbg_Addr                debug register-file read address
//   Dbg_Data                raw register-file contents at Dbg_Addr
//   WB_RegWrite             EX/WB write enable
//   WB_Rd                   EX/WB destination register
//   WB_Data                 EX/WB result
// ---------------------------------------------------------------------------
module id_ex_wb_datapath #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IF_ID_RegWrite,
    input  logic              IF_ID_SMCtrl,
    input  logic [7:0]        IF_ID_Instruction_Code,
    input  logic [2:0]        Dbg_Addr,
    output logic [DATA_W-1:0] Dbg_Data,
    output logic              WB_RegWrite,
    output logic [2:0]        WB_Rd,
    output logic [DATA_W-1:0] WB_Data
);

    // Shift left with zero fill, truncated back to the datapath width.
    function automatic logic [DATA_W-1:0] shl_trunc(input logic [DATA_W-1:0] val,
                                                    input logic [2:0]        amt);
        shl_trunc = val << amt;
    endfunction

    logic [DATA_W-1:0] rf [NUM_REGS];

    // ID/EX register (vld doubles as the RegWrite of the instruction it carries)
    logic              vld_p1;
    logic              sm_p1;
    logic [2:0]        rd_p1;
    logic [2:0]        shamt_p1;
    logic [DATA_W-1:0] opnd_p1;

    // EX/WB register
    logic              vld_p2;
    logic [2:0]        rd_p2;
    logic [DATA_W-1:0] data_p2;

    // ---- ID stage --------------------------------------------------------
    logic [2:0]        rd_p0;
    logic [2:0]        rs_p0;
    logic [2:0]        src_p0;
    logic [DATA_W-1:0] opnd_p0;
    logic [DATA_W-1:0] ex_result_p1;
    logic              unused_opcode;

    assign unused_opcode = ^IF_ID_Instruction_Code[7:6];

    assign rd_p0  = IF_ID_Instruction_Code[5:3];
    assign rs_p0  = IF_ID_Instruction_Code[2:0];
    // SLL reads its own destination; MOV reads rs.
    assign src_p0 = IF_ID_SMCtrl ? rd_p0 : rs_p0;

    // Newest producer wins. The EX/WB path also covers the same-edge case
    // where the register file is being written while ID reads it.
    always_comb begin
        opnd_p0 = rf[src_p0];
        if (vld_p1 && (rd_p1 == src_p0)) begin
            opnd_p0 = ex_result_p1;
        end else if (vld_p2 && (rd_p2 == src_p0)) begin
            opnd_p0 = data_p2;
        end
    end

    // ---- ID/EX boundary --------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vld_p1   <= 1'b0;
            sm_p1    <= 1'b0;
            rd_p1    <= 3'd0;
            shamt_p1 <= 3'd0;
            opnd_p1  <= '0;
        end else begin
            vld_p1   <= IF_ID_RegWrite;
            sm_p1    <= IF_ID_SMCtrl;
            rd_p1    <= rd_p0;
            shamt_p1 <= rs_p0;
            opnd_p1  <= opnd_p0;
        end
    end

    // ---- EX stage --------------------------------------------------------
    assign ex_result_p1 = sm_p1 ? shl_trunc(opnd_p1, shamt_p1) : opnd_p1;

    // ---- EX/WB boundary --------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            vld_p2  <= 1'b0;
            rd_p2   <= 3'd0;
            data_p2 <= '0;
        end else begin
            vld_p2  <= vld_p1;
            rd_p2   <= rd_p1;
            data_p2 <= ex_result_p1;
        end
    end

    assign WB_RegWrite = vld_p2;
    assign WB_Rd       = rd_p2;
    assign WB_Data     = data_p2;

    // ---- Write-back / register file --------------------------------------
    // Reset preloads R[i] = i so the pipeline has known, distinct operands.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= DATA_W'(i);
            end
        end else if (vld_p2) begin
            rf[rd_p2] <= data_p2;
        end
    end

    assign Dbg_Data = rf[Dbg_Addr];

endmodule

// File: tb/tb_id_ex_wb_datapath.sv
// ---------------------------------------------------------------------------
// tb_id_ex_wb_datapath
//
// Directed-vector bench for id_ex_wb_datapath. Inputs are driven and outputs
// sampled at the falling clock edge; expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_id_ex_wb_datapath;

    logic       Clk;
    logic       Reset;
    logic       IF_ID_RegWrite;
    logic       IF_ID_SMCtrl;
    logic [7:0] IF_ID_Instruction_Code;
    logic [2:0] Dbg_Addr;
    logic [7:0] Dbg_Data;
    logic       WB_RegWrite;
    logic [2:0] WB_Rd;
    logic [7:0] WB_Data;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_wb_datapath #(
        .DATA_W   (8),
        .NUM_REGS (8)
    ) dut (
        .Clk                    (Clk),
        .Reset                  (Reset),
        .IF_ID_RegWrite         (IF_ID_RegWrite),
        .IF_ID_SMCtrl           (IF_ID_SMCtrl),
        .IF_ID_Instruction_Code (IF_ID_Instruction_Code),
        .Dbg_Addr               (Dbg_Addr),
        .Dbg_Data               (Dbg_Data),
        .WB_RegWrite            (WB_RegWrite),
        .WB_Rd                  (WB_Rd),
        .WB_Data                (WB_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic rw, input logic [2:0] rd,
                            input logic [7:0] data);
        check({tag, ".rw"},   32'(WB_RegWrite), 32'(rw));
        check({tag, ".rd"},   32'(WB_Rd),       32'(rd));
        check({tag, ".data"}, 32'(WB_Data),     32'(data));
    endtask

    task automatic check_reg(input logic [2:0] idx, input logic [7:0] exp);
        Dbg_Addr = idx;
        #1;
        check($sformatf("R%0d", idx), 32'(Dbg_Data), 32'(exp));
    endtask

    // Drive one instruction (called at a falling edge) and advance one cycle.
    task automatic step(input logic rw, input logic sm, input logic [7:0] code);
        IF_ID_RegWrite         = rw;
        IF_ID_SMCtrl           = sm;
        IF_ID_Instruction_Code = code;
        @(negedge Clk);
    endtask

    task automatic bubble();
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        bubble();
        Reset = 1'b1;
    endtask

    initial begin
        Reset                  = 1'b0;
        IF_ID_RegWrite         = 1'b0;
        IF_ID_SMCtrl           = 1'b0;
        IF_ID_Instruction_Code = 8'h00;
        Dbg_Addr               = 3'd0;
        @(negedge Clk);

        // Reset state: R[i] = i, WB bus idle even with a live instruction applied.
        for (int i = 0; i < 8; i++) check_reg(3'(i), 8'(i));
        step(1'b1, 1'b0, 8'h0D);
        step(1'b1, 1'b0, 8'h0D);
        check_wb("in_reset", 1'b0, 3'd0, 8'h00);
        IF_ID_RegWrite = 1'b0;
        Reset = 1'b1;
        bubble();

        // MOV R1,R5
        step(1'b1, 1'b0, 8'h0D);
        bubble();
        check_wb("mov_r1_r5", 1'b1, 3'd1, 8'h05);
        bubble();
        check_reg(3'd1, 8'h05);

        // SLL R2,3 then SLL R7,7 (0x380 truncates to 0x80)
        step(1'b1, 1'b1, 8'h53);
        bubble();
        check_wb("sll_r2_3", 1'b1, 3'd2, 8'h10);
        step(1'b1, 1'b1, 8'h7F);
        bubble();
        check_wb("sll_r7_7", 1'b1, 3'd7, 8'h80);
        bubble();
        check_reg(3'd2, 8'h10);
        check_reg(3'd7, 8'h80);

        // EX forward chain: MOV R3,R7; SLL R3,1; MOV R4,R3
        do_reset();
        step(1'b1, 1'b0, 8'h1F);
        step(1'b1, 1'b1, 8'h59);
        check_wb("chain0", 1'b1, 3'd3, 8'h07);
        step(1'b1, 1'b0, 8'h23);
        check_wb("chain1", 1'b1, 3'd3, 8'h0E);
        bubble();
        check_wb("chain2", 1'b1, 3'd4, 8'h0E);
        bubble();
        bubble();
        check_reg(3'd3, 8'h0E);
        check_reg(3'd4, 8'h0E);

        // WB forward on the same edge R6 is written: MOV R6,R1; bubble; MOV R0,R6
        step(1'b1, 1'b0, 8'h31);
        bubble();
        step(1'b1, 1'b0, 8'h06);
        bubble();
        check_wb("wbfwd", 1'b1, 3'd0, 8'h01);
        bubble();
        bubble();
        check_reg(3'd0, 8'h01);
        check_reg(3'd6, 8'h01);

        // Register-file path: MOV R6,R1; two bubbles; MOV R0,R6
        do_reset();
        step(1'b1, 1'b0, 8'h31);
        bubble();
        bubble();
        step(1'b1, 1'b0, 8'h06);
        bubble();
        check_wb("rfpath", 1'b1, 3'd0, 8'h01);

        // Bubbles naming rd=R6 must neither forward nor write
        do_reset();
        step(1'b0, 1'b0, 8'h31);
        step(1'b0, 1'b0, 8'h31);
        step(1'b1, 1'b0, 8'h06);
        check_wb("bubble_wb", 1'b0, 3'd6, 8'h01);
        bubble();
        check_wb("nofwd", 1'b1, 3'd0, 8'h06);
        bubble();
        check_reg(3'd6, 8'h06);
        check_reg(3'd0, 8'h06);

        // Mid-stream reset with three instructions in flight
        step(1'b1, 1'b0, 8'h0D);
        step(1'b1, 1'b1, 8'h53);
        step(1'b1, 1'b0, 8'h1F);
        check_reg(3'd1, 8'h05);
        Reset = 1'b0;
        #1;
        check_wb("midrst_now", 1'b0, 3'd0, 8'h00);
        check_reg(3'd1, 8'h01);
        check_reg(3'd0, 8'h00);
        step(1'b1, 1'b0, 8'h0D);
        check_wb("midrst_hold", 1'b0, 3'd0, 8'h00);
        IF_ID_RegWrite = 1'b0;
        Reset = 1'b1;
        step(1'b1, 1'b1, 8'h7F);
        bubble();
        check_wb("resume", 1'b1, 3'd7, 8'h80);
        bubble();
        check_reg(3'd7, 8'h80);
        check_reg(3'd2, 8'h02);
        check_reg(3'd3, 8'h03);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_wb_datapath.md
Name: id_ex_wb_datapath

Overview:
- Back end of the 8-bit MOV/SLL pipeline. Sits directly downstream of the IF/ID pipeline register and consumes its IF_ID_Instruction_Code, IF_ID_RegWrite and IF_ID_SMCtrl outputs.
- Contains the ID stage (8x8 register file read plus operand forwarding), the ID/EX register, the EX stage (move or shift-left), the EX/WB register, and the write-back into the register file.
- Exposes the write-back bus and a debug read port for verification.

Parameters:
- DATA_W, 8, register and datapath width.
- NUM_REGS, 8, register count; address width is 3 (fixed by instruction format).

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- IF_ID_RegWrite  input  1  instruction in ID writes its destination.
- IF_ID_SMCtrl  input  1  1 = SLL, 0 = MOV.
- IF_ID_Instruction_Code  input  8  [7:6] opcode (ignored here), [5:3] rd, [2:0] rs or shamt.
- Dbg_Addr  input  3  debug register-file read address.
- Dbg_Data  output  8  combinational register-file contents at Dbg_Addr; no forwarding applied.
- WB_RegWrite  output  1  EX/WB write enable.
- WB_Rd  output  3  EX/WB destination.
- WB_Data  output  8  EX/WB result.

Behaviour:
- Reset (Reset=0, asynchronous, any time including mid-stream):
  - Register file R[i] = i (R0=0x00 ... R7=0x07).
  - ID/EX and EX/WB registers cleared: RegWrite=0, rd=0, operand=0, SMCtrl=0, shamt=0.
  - WB_RegWrite=0, WB_Rd=0, WB_Data=0.
  - Instructions in flight are discarded; no register-file write occurs.
- Instruction semantics:
  - MOV (SMCtrl=0): R[rd] <= R[rs].
  - SLL (SMCtrl=1): R[rd] <= R[rd] << shamt, where shamt = bits [2:0] (range 0..7). Zero fill; result truncated to 8 bits.
- ID source select: src = SMCtrl ? rd : rs.
- ID operand forwarding, priority newest first:
  - If ID/EX.RegWrite and ID/EX.rd == src: use the EX result (combinational).
  - Else if EX/WB.RegWrite and EX/WB.rd == src: use WB_Data.
  - Else use R[src].
  - Forwarding ignores opcode bits and compares only when the producer's RegWrite=1.
- ID/EX register latches RegWrite, SMCtrl, rd, shamt and the forwarded operand every edge. No stall or flush input exists; every cycle advances.
- EX: result = SMCtrl ? (operand << shamt)[7:0] : operand.
- EX/WB register latches RegWrite, rd and result every edge; these drive the WB_* outputs.
- Write-back: on each edge with WB_RegWrite=1, R[WB_Rd] <= WB_Data.
- Same-edge case: an instruction in ID reading the register being written at that edge gets the new value through the EX/WB forward path. No stale read is permitted.
- Latency:
  - Instruction present at IF_ID during cycle n appears on WB_* during cycle n+2.
  - Register file and Dbg_Data reflect the write from cycle n+3.
- A bubble (IF_ID_RegWrite=0) propagates with RegWrite=0 and never writes or forwards.
- Back-to-back dependent instructions need no stalls.

Test Plan:
- Reset, then step Dbg_Addr 0..7 -> Dbg_Data = 0x00..0x07. Hold all WB_* = 0 while Reset=0.
- MOV R1,R5 (0x0D, RW=1, SM=0) followed by bubbles -> WB_RegWrite=1, WB_Rd=1, WB_Data=0x05 two cycles later; then Dbg_Addr=1 -> 0x05.
- SLL R2,3 (0x53, SM=1) -> WB_Data=0x10. SLL R7,7 (0x7F) -> WB_Data=0x80, confirming truncation of 0x380.
- EX forward chain: MOV R3,R7 (0x1F); SLL R3,1 (0x59); MOV R4,R3 (0x23) on consecutive cycles -> WB_Data sequence 0x07, 0x0E, 0x0E. Final R3=0x0E, R4=0x0E.
- WB forward and same-edge write:
  - MOV R6,R1 (0x31); bubble; MOV R0,R6 (0x06) -> R0=0x01.
  - MOV R6,R1 with two bubbles, then MOV R0,R6 -> R0=0x01 from the register file.
  - A bubble with rd=R6 but RW=0 must not forward.
- Assert Reset mid-stream with three instructions in flight -> WB_* = 0 immediately, register file back to R[i]=i. After release, the pipeline resumes cleanly from the next instruction.
